// File: rtl/led_pkg.sv
// Shared types for the press counter.
//   state_e : key FSM states (IDLE, HELD, REPEAT)
//   bcd_t   : one 4-bit BCD digit
//   max2    : larger of two ints, for sizing the hold timer
package led_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  typedef logic [3:0] bcd_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/press_counter_bcd_inc2.sv
// bcd_inc2: next-state logic for a two-digit BCD count with a MAX_COUNT wrap.
//   tens_i/ones_i : current digits
//   inc_i         : apply one increment
//   clr_i         : force 00; wins over inc_i and suppresses both strobes
//   tens_o/ones_o : next digits
//   inc_pulse_o   : an increment took effect
//   wrap_o        : that increment went MAX_COUNT -> 00
module bcd_inc2
  import led_pkg::*;
#(
  parameter int MAX_COUNT = 99
) (
  input  bcd_t tens_i,
  input  bcd_t ones_i,
  input  logic inc_i,
  input  logic clr_i,
  output bcd_t tens_o,
  output bcd_t ones_o,
  output logic inc_pulse_o,
  output logic wrap_o
);

  localparam bcd_t MAX_T = bcd_t'(MAX_COUNT / 10);
  localparam bcd_t MAX_O = bcd_t'(MAX_COUNT % 10);

  always_comb begin
    tens_o      = tens_i;
    ones_o      = ones_i;
    inc_pulse_o = 1'b0;
    wrap_o      = 1'b0;
    if (clr_i) begin
      tens_o = '0;
      ones_o = '0;
    end else if (inc_i) begin
      inc_pulse_o = 1'b1;
      if (tens_i == MAX_T && ones_i == MAX_O) begin
        tens_o = '0;
        ones_o = '0;
        wrap_o = 1'b1;
      end else if (ones_i == 4'd9) begin
        ones_o = '0;
        tens_o = tens_i + 4'd1;
      end else begin
        ones_o = ones_i + 4'd1;
      end
    end
  end

endmodule

// File: rtl/press_counter.sv
// press_counter: counts key presses as two BCD digits, wrapping after MAX_COUNT.
// With PRESS_COUNTER_AUTO_REPEAT_EN defined, a key held for REPEAT_DLY cycles
// starts auto-repeat with one increment every REPEAT_PERIOD cycles; without it
// every press gives exactly one increment and the repeat timer does not exist.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   key_en    : debounced key level, high = pressed
//   clr       : synchronous clear of the count
//   bcd_tens  : tens digit
//   bcd_ones  : ones digit
//   inc_pulse : one-cycle strobe with each new count value
//   wrap      : one-cycle strobe with inc_pulse when the count wrapped to 00
module press_counter
  import led_pkg::*;
#(
  parameter int MAX_COUNT     = 99,
  parameter int REPEAT_DLY    = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_en,
  input  logic       clr,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       inc_pulse,
  output logic       wrap
);

  logic   key_q, arm_q, rise;
  state_e state_q;
  logic   inc_q;
  bcd_t   tens_q, ones_q, tens_d, ones_d;
  logic   inc_pulse_d, wrap_d, inc_pulse_q, wrap_q;

  // arm_q stays low until key_en has been seen low after reset, so a key that
  // is already held when reset releases does not count as a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      key_q <= key_en;
      arm_q <= arm_q | ~key_en;
    end
  end

  assign rise = key_en & ~key_q & arm_q;

  // inc_q is the registered increment request; the count takes it one cycle
  // later, giving the two-cycle key-to-count latency.
`ifdef PRESS_COUNTER_AUTO_REPEAT_EN
  localparam int TMAX = max2(REPEAT_DLY, REPEAT_PERIOD);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] DLY_END = TW'(REPEAT_DLY - 1);
  localparam logic [TW-1:0] PER_END = TW'(REPEAT_PERIOD - 1);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_inc;

  // Saturating step: holds at all-ones instead of wrapping.
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      inc_q   <= 1'b0;
    end else begin
      inc_q <= 1'b0;
      case (state_q)
        IDLE: if (rise) begin
          inc_q   <= 1'b1;
          timer_q <= '0;
          state_q <= HELD;
        end
        HELD: begin
          if (!key_en) begin
            state_q <= IDLE;
            timer_q <= '0;
          end else if (timer_q == DLY_END) begin
            inc_q   <= 1'b1;
            timer_q <= '0;
            state_q <= REPEAT;
          end else begin
            timer_q <= timer_inc;
          end
        end
        REPEAT: begin
          if (!key_en) begin
            state_q <= IDLE;
            timer_q <= '0;
          end else if (timer_q == PER_END) begin
            inc_q   <= 1'b1;
            timer_q <= '0;
          end else begin
            timer_q <= timer_inc;
          end
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end
`else
  // Timing parameters have no effect in this build.
  logic unused_cfg;
  assign unused_cfg = ^{REPEAT_DLY, REPEAT_PERIOD};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      inc_q   <= 1'b0;
    end else begin
      inc_q <= 1'b0;
      case (state_q)
        IDLE: if (rise) begin
          inc_q   <= 1'b1;
          state_q <= HELD;
        end
        HELD: if (!key_en) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
`endif

  bcd_inc2 #(.MAX_COUNT(MAX_COUNT)) u_inc (
    .tens_i      (tens_q),
    .ones_i      (ones_q),
    .inc_i       (inc_q),
    .clr_i       (clr),
    .tens_o      (tens_d),
    .ones_o      (ones_d),
    .inc_pulse_o (inc_pulse_d),
    .wrap_o      (wrap_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tens_q      <= '0;
      ones_q      <= '0;
      inc_pulse_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      inc_pulse_q <= inc_pulse_d;
      wrap_q      <= wrap_d;
    end
  end

  assign bcd_tens  = tens_q;
  assign bcd_ones  = ones_q;
  assign inc_pulse = inc_pulse_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_press_counter.sv
// Directed bench for press_counter: a default MAX_COUNT=99 instance and a
// MAX_COUNT=12 instance sharing clock, reset and clear.
module tb_press_counter;

  logic       clk = 1'b0;
  logic       rst_n, key_en, clr, key12;
  logic [3:0] bcd_tens, bcd_ones, tens12, ones12;
  logic       inc_pulse, wrap, inc12, wrap12;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_inc = 0;
  int n_wrap = 0;
  int n_wrap12 = 0;
  int inc_cyc[$];

  always #5 clk = ~clk;

  press_counter #(.MAX_COUNT(99), .REPEAT_DLY(20), .REPEAT_PERIOD(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .key_en(key_en), .clr(clr),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .inc_pulse(inc_pulse), .wrap(wrap)
  );

  press_counter #(.MAX_COUNT(12), .REPEAT_DLY(20), .REPEAT_PERIOD(5)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .key_en(key12), .clr(clr),
    .bcd_tens(tens12), .bcd_ones(ones12), .inc_pulse(inc12), .wrap(wrap12)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (inc_pulse) begin
      n_inc = n_inc + 1;
      inc_cyc.push_back(cyc);
    end
    if (wrap)   n_wrap   = n_wrap + 1;
    if (wrap12) n_wrap12 = n_wrap12 + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int hold, input int gap);
    key_en = 1'b1;
    tick(hold);
    key_en = 1'b0;
    tick(gap);
  endtask

  task automatic press12;
    key12 = 1'b1;
    tick(4);
    key12 = 1'b0;
    tick(3);
  endtask

  function automatic int cnt();
    return int'(bcd_tens) * 10 + int'(bcd_ones);
  endfunction

  initial begin
    int base, wbase, p, qb;
    int exp_off[$];
    rst_n = 1'b0; key_en = 1'b0; clr = 1'b0; key12 = 1'b0;
    tick(3);
    chk("rst_tens", int'(bcd_tens), 0);
    chk("rst_ones", int'(bcd_ones), 0);
    chk("rst_inc",  int'(inc_pulse), 0);
    chk("rst_wrap", int'(wrap), 0);
    rst_n = 1'b1;
    tick(2);

    // three presses, first one with latency checked cycle by cycle
    base = n_inc; wbase = n_wrap;
    key_en = 1'b1;
    tick(1);
    chk("lat_c1_cnt", cnt(), 0);
    tick(1);
    chk("lat_c2_cnt", cnt(), 1);
    chk("lat_c2_inc", int'(inc_pulse), 1);
    tick(2);
    key_en = 1'b0;
    tick(3);
    press(4, 3);
    press(4, 3);
    chk("three_cnt",   cnt(), 3);
    chk("three_incs",  n_inc - base, 3);
    chk("three_wraps", n_wrap - wbase, 0);

    // ones carry into tens
    repeat (6) press(4, 3);
    chk("cnt09", cnt(), 9);
    press(4, 3);
    chk("carry_tens", int'(bcd_tens), 1);
    chk("carry_ones", int'(bcd_ones), 0);

    // 99 -> 00 with wrap
    repeat (89) press(4, 3);
    chk("cnt99", cnt(), 99);
    wbase = n_wrap;
    key_en = 1'b1;
    tick(2);
    chk("wrap_cnt",  cnt(), 0);
    chk("wrap_inc",  int'(inc_pulse), 1);
    chk("wrap_flag", int'(wrap), 1);
    tick(2);
    key_en = 1'b0;
    tick(3);
    chk("wrap_once", n_wrap - wbase, 1);

    // clr colliding with the increment at 42
    repeat (42) press(4, 3);
    chk("cnt42", cnt(), 42);
    key_en = 1'b1;
    tick(1);
    clr = 1'b1;
    tick(1);
    chk("clr_cnt",  cnt(), 0);
    chk("clr_inc",  int'(inc_pulse), 0);
    chk("clr_wrap", int'(wrap), 0);
    clr = 1'b0;
    key_en = 1'b0;
    tick(3);
    chk("clr_hold", cnt(), 0);

    // key held 40 cycles
    qb = inc_cyc.size();
    p = cyc;
    press(40, 5);
`ifdef PRESS_COUNTER_AUTO_REPEAT_EN
    exp_off = '{2, 22, 27, 32, 37};
`else
    exp_off = '{2};
`endif
    chk("hold_cnt", cnt(), exp_off.size());
    chk("hold_nincs", inc_cyc.size() - qb, exp_off.size());
    foreach (exp_off[i])
      if (qb + i < inc_cyc.size())
        chk($sformatf("hold_off%0d", i), inc_cyc[qb + i] - p, exp_off[i]);

    // reset mid-hold, key kept high through release
    key_en = 1'b1;
    tick(30);
    rst_n = 1'b0;
    tick(2);
    chk("rst2_cnt", cnt(), 0);
    chk("rst2_inc", int'(inc_pulse), 0);
    base = n_inc;
    rst_n = 1'b1;
    tick(30);
    chk("held_rel_cnt",  cnt(), 0);
    chk("held_rel_incs", n_inc - base, 0);
    key_en = 1'b0;
    tick(1);
    key_en = 1'b1;
    tick(2);
    chk("repress_cnt", cnt(), 1);
    key_en = 1'b0;
    tick(3);

    // MAX_COUNT=12 instance
    wbase = n_wrap12;
    repeat (12) press12();
    chk("m12_tens12", int'(tens12), 1);
    chk("m12_ones12", int'(ones12), 2);
    press12();
    chk("m12_wrap_cnt", int'(tens12) * 10 + int'(ones12), 0);
    chk("m12_wraps", n_wrap12 - wbase, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/press_counter.md
PRESS_COUNTER -- requirements
Module: press_counter

Interface
REQ-001 Parameter MAX_COUNT, default 99, meaning highest count value before wrap to 0; legal range 1..99.
REQ-002 Parameter REPEAT_DLY, default 50_000_000, meaning cycles key_en must stay high before auto-repeat starts.
REQ-003 Parameter REPEAT_PERIOD, default 10_000_000, meaning cycles between auto-repeat increments.
REQ-004 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 key_en  input  1  debounced key level from the upstream debounce stage; high = pressed.
REQ-007 clr  input  1  synchronous clear of the count.
REQ-008 bcd_tens  output  4  tens digit of count, BCD.
REQ-009 bcd_ones  output  4  ones digit of count, BCD.
REQ-010 inc_pulse  output  1  one-cycle strobe, high in the cycle after each increment.
REQ-011 wrap  output  1  one-cycle strobe, high in the same cycle as inc_pulse when count went MAX_COUNT -> 0.

Function
REQ-012 key_en SHALL be registered once; a rise SHALL be detected as registered 0 -> current 1.
REQ-013 FSM states SHALL be IDLE, HELD, REPEAT.
REQ-014 IDLE: on key_en rise, increment once, clear hold timer, go to HELD.
REQ-015 HELD: key_en low -> IDLE; timer reaching REPEAT_DLY-1 -> increment once, clear timer, go to REPEAT (only with AUTO_REPEAT_EN).
REQ-016 REPEAT: key_en low -> IDLE; timer reaching REPEAT_PERIOD-1 -> increment once, clear timer, stay.
REQ-017 Increment latency: the count outputs SHALL show the new value 1 cycle after the triggering edge/timer cycle, i.e. 2 cycles after key_en rises at the input.
REQ-018 Count SHALL be held as two BCD digits; ones 9 -> 0 carries into tens; digits never hold 10..15.
REQ-019 Increment from value MAX_COUNT SHALL yield 00 and assert wrap with inc_pulse.
REQ-020 clr SHALL set count to 00 next cycle, override a simultaneous increment, suppress inc_pulse/wrap, and leave FSM state and timer unchanged.
REQ-021 key_en low for any cycle SHALL return FSM to IDLE and clear the timer; a new press restarts the REPEAT_DLY wait.
REQ-022 Timer width SHALL be $clog2 of max(REPEAT_DLY, REPEAT_PERIOD); timer SHALL saturate, never wrap.

Reset
REQ-023 rst_n low SHALL force FSM IDLE, timer 0, count 00, inc_pulse 0, wrap 0, key register 0 on the next clock edge.
REQ-024 A key_en already high when rst_n releases SHALL NOT cause an increment until it falls and rises again.
REQ-025 Reset mid-repeat SHALL abort repeat with no further increments.

Configuration
REQ-026 Macro PRESS_COUNTER_AUTO_REPEAT_EN: defined -> HELD/REPEAT timed increments per REQ-015/016.
REQ-027 Undefined -> REPEAT state and timer SHALL be removed; exactly one increment per press; REPEAT_DLY/REPEAT_PERIOD ignored.

Structure
REQ-028 Shared package led_pkg SHALL hold the FSM state typedef (IDLE, HELD, REPEAT) and BCD digit type (4-bit).
REQ-029 One sub-module bcd_inc2 SHALL implement the two-digit BCD increment with MAX_COUNT wrap and wrap flag; FSM, timer and edge detect stay in press_counter.

Verification (bench uses REPEAT_DLY=20, REPEAT_PERIOD=5, MAX_COUNT=99 unless stated)
REQ-030 Reset, then 3 separate presses of 4 cycles each -> count 03, three inc_pulse strobes, wrap never high.
REQ-031 Count 09, one press -> count 10; count 99, one press -> count 00 with wrap and inc_pulse same cycle.
REQ-032 AUTO_REPEAT_EN defined, key held 40 cycles from 00 -> increments at press+2, +20, +25, +30, +35 cycles (relative to the first increment's timing), final count 05; macro undefined -> final 01.
REQ-033 clr asserted in the same cycle as an increment at count 42 -> count 00, no inc_pulse, no wrap.
REQ-034 key_en held high through rst_n release -> count stays 00 until key_en low then high, then 01.
REQ-035 MAX_COUNT=12, 13 presses from 00 -> count 00, wrap strobed exactly once.
